// File: rtl/snowf_collect_pkg.sv
// Shared constants, FSM state type and position-slice helper for snowflake collection.
package snow_pkg;

    localparam int unsigned N_SNOWF = 15;
    localparam int unsigned XW      = 10;
    localparam int unsigned YW      = 9;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } collect_state_t;

    // Bit offset of flake i inside the packed position bus.
    function automatic int unsigned snowf_off(input int unsigned i);
        return i * (XW + YW);
    endfunction

endpackage

// File: rtl/snowf_collect_if.sv
// Game-controller side bus of the snowflake collection tracker.
interface snowf_collect_if;
    import snow_pkg::*;

    logic                      frame_tick;
    logic                      level_clear;
    logic [XW-1:0]             player_x;
    logic [YW-1:0]             player_y;
    logic [N_SNOWF*(XW+YW)-1:0] snowf_pos;
    logic [N_SNOWF-1:0]        snowf_get;
    logic                      new_get;
    logic                      all_got;
    logic                      busy;

    modport master (
        output frame_tick, level_clear, player_x, player_y, snowf_pos,
        input  snowf_get, new_get, all_got, busy
    );

    modport slave (
        input  frame_tick, level_clear, player_x, player_y, snowf_pos,
        output snowf_get, new_get, all_got, busy
    );

endinterface

// File: rtl/snowf_hit_cmp.sv
// Combinational abs-diff plus inclusive rectangular hit-box compare.
module snowf_hit_cmp #(
    parameter int unsigned XW    = 10,
    parameter int unsigned YW    = 9,
    parameter int unsigned HIT_X = 16,
    parameter int unsigned HIT_Y = 16
) (
    input  logic [XW-1:0] px,
    input  logic [YW-1:0] py,
    input  logic [XW-1:0] sx,
    input  logic [YW-1:0] sy,
    output logic          hit
);

    localparam logic [XW:0] HitXLim = (XW + 1)'(HIT_X);
    localparam logic [YW:0] HitYLim = (YW + 1)'(HIT_Y);

    logic [XW:0] dx;
    logic [YW:0] dy;

    // One extra bit on each difference so the subtraction can never wrap.
    always_comb begin
        dx  = (px >= sx) ? ({1'b0, px} - {1'b0, sx}) : ({1'b0, sx} - {1'b0, px});
        dy  = (py >= sy) ? ({1'b0, py} - {1'b0, sy}) : ({1'b0, sy} - {1'b0, py});
        hit = (dx <= HitXLim) && (dy <= HitYLim);
    end

endmodule

// File: rtl/snowf_collect.sv
// Per-frame snowflake collection tracker: scans one flake per clock after each frame tick
// and accumulates sticky collected bits.
module snowf_collect
    import snow_pkg::*;
#(
    parameter int unsigned HIT_X = 16,
    parameter int unsigned HIT_Y = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    snowf_collect_if.slave bus
);

    localparam int unsigned   PW      = XW + YW;
    localparam int unsigned   IW      = $clog2(N_SNOWF);
    localparam logic [IW-1:0] LastIdx = IW'(N_SNOWF - 1);

    collect_state_t     state_q;
    logic [IW-1:0]      idx_q;
    logic [XW-1:0]      cap_x_q;
    logic [YW-1:0]      cap_y_q;
    logic [N_SNOWF-1:0] pending_q;
    logic [N_SNOWF-1:0] get_q;
    logic               new_get_q;
    logic               all_got_q;
    logic               busy_q;

    logic [PW-1:0]      cur_pos;
    logic               hit;

    // Live position of the flake under evaluation this cycle.
    assign cur_pos = bus.snowf_pos[snowf_off(32'(idx_q)) +: PW];

    snowf_hit_cmp #(
        .XW    (XW),
        .YW    (YW),
        .HIT_X (HIT_X),
        .HIT_Y (HIT_Y)
    ) u_hit_cmp (
        .px  (cap_x_q),
        .py  (cap_y_q),
        .sx  (cur_pos[PW-1:YW]),
        .sy  (cur_pos[YW-1:0]),
        .hit (hit)
    );

    // Scan FSM with registered outputs; level_clear aborts any scan and wipes collected state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            cap_x_q   <= '0;
            cap_y_q   <= '0;
            pending_q <= '0;
            get_q     <= '0;
            new_get_q <= 1'b0;
            all_got_q <= 1'b0;
            busy_q    <= 1'b0;
        end else if (bus.level_clear) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            pending_q <= '0;
            get_q     <= '0;
            new_get_q <= 1'b0;
            all_got_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            new_get_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (bus.frame_tick) begin
                        cap_x_q   <= bus.player_x;
                        cap_y_q   <= bus.player_y;
                        idx_q     <= '0;
                        pending_q <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= SCAN;
                    end
                end
                SCAN: begin
                    if (hit) begin
                        pending_q[idx_q] <= 1'b1;
                    end
                    if (idx_q == LastIdx) begin
                        idx_q   <= '0;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q + 1'b1;
                    end
                end
                DONE: begin
                    get_q     <= get_q | pending_q;
                    all_got_q <= &(get_q | pending_q);
                    new_get_q <= |(pending_q & ~get_q);
                    busy_q    <= 1'b0;
                    state_q   <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.snowf_get = get_q;
    assign bus.new_get   = new_get_q;
    assign bus.all_got   = all_got_q;
    assign bus.busy      = busy_q;

endmodule

// File: tb/tb_snowf_collect.sv
// Self-checking bench for snowf_collect against a behavioural collection model.
module tb_snowf_collect;
    import snow_pkg::*;

    logic clk;
    logic rst_n;

    snowf_collect_if bus ();

    snowf_collect #(
        .HIT_X (16),
        .HIT_Y (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Reference state: flake coordinates and the collected set.
    logic [XW-1:0]      fx [N_SNOWF];
    logic [YW-1:0]      fy [N_SNOWF];
    logic [N_SNOWF-1:0] coll;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive_pos();
        for (int i = 0; i < N_SNOWF; i++) begin
            bus.snowf_pos[i*(XW+YW) +: (XW+YW)] = {fx[i], fy[i]};
        end
    endtask

    function automatic logic [N_SNOWF-1:0] model_hits(input int px, input int py);
        logic [N_SNOWF-1:0] h;
        int dx, dy;
        h = '0;
        for (int i = 0; i < N_SNOWF; i++) begin
            dx = px - int'(fx[i]);
            dy = py - int'(fy[i]);
            if (dx < 0) dx = -dx;
            if (dy < 0) dy = -dy;
            h[i] = (dx <= 16) && (dy <= 16);
        end
        return h;
    endfunction

    // One frame: tick, then watch 24 cycles. extra_at/clear_at are edge offsets (-1 = none).
    task automatic run_frame(input int px, input int py, input int extra_at, input int clear_at);
        logic [N_SNOWF-1:0] hits, exp_get, old_get;
        logic exp_new;
        int busy_n, new_n, new_at;
        drive_pos();
        hits    = model_hits(px, py);
        old_get = coll;
        if (clear_at >= 0) begin
            exp_get = '0;
            exp_new = 1'b0;
        end else begin
            exp_get = coll | hits;
            exp_new = |(hits & ~coll);
        end
        bus.player_x   = XW'(px);
        bus.player_y   = YW'(py);
        bus.frame_tick = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick = 1'b0;
        busy_n = 0;
        new_n  = 0;
        new_at = -1;
        for (int j = 0; j < 24; j++) begin
            if (bus.busy) busy_n++;
            if (bus.new_get) begin
                new_n++;
                new_at = j;
            end
            if (j == 15 && clear_at < 0) check("get_not_early", 32'(bus.snowf_get), 32'(old_get));
            if (j == 16) begin
                check("snowf_get", 32'(bus.snowf_get), 32'(exp_get));
                check("all_got", 32'(bus.all_got), 32'(&exp_get));
            end
            if (clear_at >= 0 && j == clear_at + 1) check("busy_after_clear", 32'(bus.busy), 0);
            bus.frame_tick  = (j == extra_at - 1);
            bus.level_clear = (j == clear_at - 1);
            @(posedge clk);
            #1;
        end
        bus.frame_tick  = 1'b0;
        bus.level_clear = 1'b0;
        check("busy_cycles", busy_n, (clear_at >= 0) ? clear_at : 16);
        check("new_get_pulses", new_n, 32'(exp_new));
        if (exp_new) check("new_get_cycle", new_at, 16);
        coll = exp_get;
    endtask

    task automatic pulse_clear();
        bus.level_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.level_clear = 1'b0;
        coll = '0;
        check("clear_get", 32'(bus.snowf_get), 0);
        check("clear_all_got", 32'(bus.all_got), 0);
        check("clear_busy", 32'(bus.busy), 0);
    endtask

    initial begin
        int px, py, ex, cl, busy_n;
        bus.frame_tick  = 1'b0;
        bus.level_clear = 1'b0;
        bus.player_x    = '0;
        bus.player_y    = '0;
        bus.snowf_pos   = '0;
        coll            = '0;
        rst_n           = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_get", 32'(bus.snowf_get), 0);
        check("rst_new_get", 32'(bus.new_get), 0);
        check("rst_all_got", 32'(bus.all_got), 0);
        check("rst_busy", 32'(bus.busy), 0);
        rst_n = 1'b1;

        // All flakes far away: nothing collected.
        for (int i = 0; i < N_SNOWF; i++) begin
            fx[i] = 10'd400;
            fy[i] = 9'd300;
        end
        run_frame(100, 100, -1, -1);
        check("far_get_zero", 32'(bus.snowf_get), 0);

        // Single hit, then inclusive box edge and just-outside.
        fx[3] = 10'd110; fy[3] = 9'd92;
        run_frame(100, 100, -1, -1);
        check("flake3_get", 32'(bus.snowf_get), 32'h0008);
        fx[5] = 10'd116; fy[5] = 9'd84;
        fx[6] = 10'd117; fy[6] = 9'd100;
        run_frame(100, 100, -1, -1);
        check("edge_get", 32'(bus.snowf_get), 32'h0028);

        // Repeat tick: no change, no pulse. Overrun tick ignored. Clear mid-scan aborts.
        run_frame(100, 100, -1, -1);
        run_frame(100, 100, 5, -1);
        run_frame(100, 100, 5, 8);

        // Walk over all flakes, one per frame.
        for (int i = 0; i < N_SNOWF; i++) begin
            fx[i] = 10'(20 + 40 * i);
            fy[i] = 9'd200;
        end
        for (int i = 0; i < N_SNOWF; i++) begin
            px = 20 + 40 * i + int'($urandom_range(0, 32)) - 16;
            py = 200 + int'($urandom_range(0, 32)) - 16;
            run_frame(px, py, -1, -1);
        end
        check("walk_all_got", 32'(bus.all_got), 1);
        pulse_clear();

        // Clear and tick together: clear wins, no scan.
        run_frame(20, 200, -1, -1);
        bus.frame_tick  = 1'b1;
        bus.level_clear = 1'b1;
        @(posedge clk);
        #1;
        bus.frame_tick  = 1'b0;
        bus.level_clear = 1'b0;
        coll   = '0;
        busy_n = 0;
        repeat (20) begin
            if (bus.busy) busy_n++;
            @(posedge clk);
            #1;
        end
        check("tick_clr_busy", busy_n, 0);
        check("tick_clr_get", 32'(bus.snowf_get), 0);

        // Randomized frames with flakes clustered around the player.
        for (int f = 0; f < 30; f++) begin
            px = int'($urandom_range(20, 619));
            py = int'($urandom_range(20, 459));
            for (int i = 0; i < N_SNOWF; i++) begin
                if ($urandom_range(0, 2) == 0) begin
                    fx[i] = 10'(px + int'($urandom_range(0, 40)) - 20);
                    fy[i] = 9'(py + int'($urandom_range(0, 40)) - 20);
                end else begin
                    fx[i] = 10'($urandom_range(0, 639));
                    fy[i] = 9'($urandom_range(0, 479));
                end
            end
            ex = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : -1;
            cl = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, 15)) : -1;
            if (cl >= 0 && ex >= cl) ex = -1;
            run_frame(px, py, ex, cl);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
